piso_serializer: RTL and testbench

Parallel-in serial-out transmitter with valid/ready handshakes on both sides. It accepts a WIDTH-bit word from an upstream parallel register stage and shifts it out one bit per accepted serial beat, flagging the final bit of each word. It converts parallel register data back to a serial stream, is the transmit end of the serial link, and supports back-to-back words with no idle bubble.

---
 rtl/piso_serializer.sv | 79 +++++++
 tb/tb_piso_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready on both sides.
// Accepts a WIDTH-bit word and shifts it out one bit per serial beat, flagging the final bit.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh, sh_next;
  logic [CW-1:0]    cnt, cnt_next, cnt_inc;
  logic             last_next;
  logic             load_hs;
  logic             beat;

  // sout is taken straight from the output end of the shift register, which is zero while idle
  assign sout       = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign sout_valid = (state == SHIFT);
  assign busy       = sout_valid;
  assign load_ready = !rst && (!sout_valid || (last && sout_ready));
  assign load_hs    = load_valid && load_ready;
  assign beat       = sout_valid && sout_ready;
  assign cnt_inc    = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_next;
      sh    <= sh_next;
      cnt   <= cnt_next;
      last  <= last_next;
    end
  end

  // A load on the last-bit beat takes priority, giving back-to-back words with no bubble
  always_comb begin
    state_next = state;
    sh_next    = sh;
    cnt_next   = cnt;
    last_next  = last;
    if (load_hs) begin
      state_next = SHIFT;
      sh_next    = d;
      cnt_next   = '0;
      last_next  = (WIDTH == 1);
    end else if (beat) begin
      if (last) begin
        state_next = IDLE;
        sh_next    = '0;
        cnt_next   = '0;
        last_next  = 1'b0;
      end else begin
        sh_next    = MSB_FIRST ? (sh << 1) : (sh >> 1);
        cnt_next   = cnt_inc;
        last_next  = (cnt_inc == CNT_LAST);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first 4-bit instances plus a 1-bit instance.
// Inputs change and outputs are checked on the falling edge, away from the active edge.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;

  logic       aLv, aLr, aSout, aSv, aSr, aLast, aBusy;
  logic [3:0] aD;
  logic       bLv, bLr, bSout, bSv, bSr, bLast, bBusy;
  logic [3:0] bD;
  logic       cLv, cLr, cSout, cSv, cSr, cLast, cBusy;
  logic [0:0] cD;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dutA (
    .clk(clk), .rst(rst), .load_valid(aLv), .load_ready(aLr), .d(aD),
    .sout(aSout), .sout_valid(aSv), .sout_ready(aSr), .last(aLast), .busy(aBusy));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dutB (
    .clk(clk), .rst(rst), .load_valid(bLv), .load_ready(bLr), .d(bD),
    .sout(bSout), .sout_valid(bSv), .sout_ready(bSr), .last(bLast), .busy(bBusy));

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dutC (
    .clk(clk), .rst(rst), .load_valid(cLv), .load_ready(cLr), .d(cD),
    .sout(cSout), .sout_valid(cSv), .sout_ready(cSr), .last(cLast), .busy(cBusy));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input int which, input logic lv, input logic [3:0] dv, input logic sr);
    case (which)
      0: begin aLv = lv; aD = dv; aSr = sr; end
      1: begin bLv = lv; bD = dv; bSr = sr; end
      default: begin cLv = lv; cD = dv[0]; cSr = sr; end
    endcase
  endtask

  task automatic expectOut(input int which, input string tag, input logic s, input logic v,
                           input logic l, input logic lr);
    logic os, ov, ol, olr, ob;
    case (which)
      0: begin os = aSout; ov = aSv; ol = aLast; olr = aLr; ob = aBusy; end
      1: begin os = bSout; ov = bSv; ol = bLast; olr = bLr; ob = bBusy; end
      default: begin os = cSout; ov = cSv; ol = cLast; olr = cLr; ob = cBusy; end
    endcase
    checkOutput({tag, ".sout"}, 32'(os), 32'(s));
    checkOutput({tag, ".sout_valid"}, 32'(ov), 32'(v));
    checkOutput({tag, ".last"}, 32'(ol), 32'(l));
    checkOutput({tag, ".load_ready"}, 32'(olr), 32'(lr));
    checkOutput({tag, ".busy"}, 32'(ob), 32'(v));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b2b;
    logic [6:0] bpSout;
    logic [6:0] bpReady;
    logic [3:0] lsbWord;
    logic [5:0] w1Pat;

    rst = 1'b1;
    applyStimulus(0, 1'b0, 4'h0, 1'b1);
    applyStimulus(1, 1'b0, 4'h0, 1'b1);
    applyStimulus(2, 1'b0, 4'h0, 1'b1);

    @(negedge clk);
    expectOut(0, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("released.load_ready", 32'(aLr), 32'd1);

    // Basic word 1010, MSB first
    applyStimulus(0, 1'b1, 4'b1010, 1'b1);
    @(negedge clk);
    aLv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectOut(0, $sformatf("basic[%0d]", i), (i == 0 || i == 2), 1'b1, (i == 3), (i == 3));
      @(negedge clk);
    end
    expectOut(0, "basic.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: 1010 then 1100 accepted on the last-bit edge
    b2b = 8'b1010_1100;
    applyStimulus(0, 1'b1, 4'b1010, 1'b1);
    @(negedge clk);
    aD = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      expectOut(0, $sformatf("b2b[%0d]", i), b2b[7-i], 1'b1, (i == 3 || i == 7), (i == 3 || i == 7));
      if (i == 4) aLv = 1'b0;
      @(negedge clk);
    end
    expectOut(0, "b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: stall three cycles on the second bit
    bpSout  = 7'b1000010;
    bpReady = 7'b1000111;
    applyStimulus(0, 1'b1, 4'b1010, 1'b1);
    @(negedge clk);
    aLv = 1'b0;
    for (int i = 0; i < 7; i++) begin
      aSr = bpReady[6-i];
      #1;
      expectOut(0, $sformatf("bp[%0d]", i), bpSout[6-i], 1'b1, (i == 6), (i == 6));
      @(negedge clk);
    end
    expectOut(0, "bp.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word, then a clean word 0110
    applyStimulus(0, 1'b1, 4'b1100, 1'b1);
    @(negedge clk);
    aLv = 1'b0;
    expectOut(0, "rstmid[0]", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expectOut(0, "rstmid[1]", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    expectOut(0, "rstmid.async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstmid.release.load_ready", 32'(aLr), 32'd1);
    applyStimulus(0, 1'b1, 4'b0110, 1'b1);
    @(negedge clk);
    aLv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectOut(0, $sformatf("after_rst[%0d]", i), (i == 1 || i == 2), 1'b1, (i == 3), (i == 3));
      @(negedge clk);
    end
    expectOut(0, "after_rst.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB first: 1101 sends 1,0,1,1 while d is scrambled
    lsbWord = 4'b1101;
    applyStimulus(1, 1'b1, lsbWord, 1'b1);
    @(negedge clk);
    bLv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bD = 4'($urandom);
      expectOut(1, $sformatf("lsb[%0d]", i), lsbWord[i], 1'b1, (i == 3), (i == 3));
      @(negedge clk);
    end
    expectOut(1, "lsb.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // WIDTH=1: continuous loads, each bit is the previous cycle's d
    w1Pat = 6'b100110;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, 1'b1, {3'b000, w1Pat[i]}, 1'b1);
      @(negedge clk);
      expectOut(2, $sformatf("w1[%0d]", i), w1Pat[i], 1'b1, 1'b1, 1'b1);
    end
    cSr = 1'b0;
    #1;
    checkOutput("w1.stall.load_ready", 32'(cLr), 32'd0);
    @(negedge clk);
    expectOut(2, "w1.stall", w1Pat[5], 1'b1, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    expectOut(2, "w1.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
